// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI transmit arbiter: state encoding, default header tag
// and the header-byte builder.
package ftdi_pkg;

  localparam logic [3:0] HDR_TAG_DEF = 4'hA;

  typedef enum logic [2:0] {
    ST_ARB_IDLE    = 3'd0,
    ST_ARB_COLLECT = 3'd1,
    ST_ARB_HEADER  = 3'd2,
    ST_ARB_LEN     = 3'd3,
    ST_ARB_PAYLOAD = 3'd4
  } arb_state_t;

  function automatic logic [7:0] build_hdr(input logic [3:0] tag, input logic [3:0] ch);
    return {tag, ch};
  endfunction

endpackage

// File: rtl/ftdi_frame_buf.sv
// Synchronous byte FIFO holding one collected burst; head byte is visible on rd_data.
module ftdi_frame_buf #(
  parameter int DEPTH = 16
) (
  input  logic       clock_in,
  input  logic       flush,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic [7:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [7:0]    r_count;
  logic          w_wr;
  logic          w_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_wr    = wr_en && (r_count < 8'(DEPTH));
  assign w_rd    = rd_en && (r_count != 8'd0);
  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

  always_ff @(posedge clock_in) begin
    if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 8'd1;
        2'b01:   r_count <= r_count - 8'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; flushed pointers make stale bytes unreachable.
  always_ff @(posedge clock_in) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Round-robin arbiter sharing the FTDI transmit byte path: collects a burst from one channel,
// then emits header {HDR_TAG, ch}, length byte and payload.
module ftdi_tx_arbiter
  import ftdi_pkg::*;
#(
  parameter int         N_CH      = 4,
  parameter int         MAX_BURST = 16,
  parameter int         TIMEOUT   = 255,
  parameter logic [3:0] HDR_TAG   = HDR_TAG_DEF
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   req_valid,
  input  logic [8*N_CH-1:0] req_data,
  input  logic [N_CH-1:0]   req_last,
  output logic [N_CH-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [3:0]        grant_id,
  output logic              busy,
  output arb_state_t        dbg_state
);
  // Handshake: a beat moves on a posedge where valid && ready; the source holds valid/data
  // stable until then, and ready never depends combinationally on valid.
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic [3:0]    r_grant;
  logic [3:0]    r_rr;
  logic [IW-1:0] r_idle_cnt;
  logic [3:0]    w_pick;
  logic [3:0]    w_rr_inc;
  logic [4:0]    w_sum;
  logic [N_CH-1:0] w_rot;
  logic [N_CH-1:0] w_grant_oh;
  logic [7:0]    w_sel_data;
  logic [7:0]    w_count;
  logic [7:0]    w_rd_data;
  logic          w_found;
  logic          w_sel_valid;
  logic          w_sel_last;
  logic          w_room;
  logic          w_beat;
  logic          w_close;
  logic          w_timeout;
  logic          w_tx_acc;
  logic          w_last_pop;

  // Rotate so bit 0 is the channel at rr_ptr; the lowest set bit wins.
  assign w_rot = (req_valid >> r_rr) | (req_valid << (N_CH - int'(r_rr)));

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_found = 1'b1;
        w_sum   = 5'(j) + {1'b0, r_rr};
      end
    end
    if (w_sum >= 5'(N_CH)) w_sum = w_sum - 5'(N_CH);
    w_pick = w_sum[3:0];
  end

  assign w_rr_inc    = (r_grant == 4'(N_CH - 1)) ? 4'd0 : r_grant + 4'd1;
  assign w_grant_oh  = N_CH'(1) << r_grant;
  assign w_sel_valid = |(req_valid & w_grant_oh);
  assign w_sel_last  = |(req_last & w_grant_oh);
  assign w_sel_data  = 8'(req_data >> {r_grant, 3'b000});
  assign w_room      = w_count < 8'(MAX_BURST);
  assign w_beat      = (r_state == ST_ARB_COLLECT) && w_room && w_sel_valid;
  assign w_close     = w_beat && (w_sel_last || (w_count == 8'(MAX_BURST - 1)));
  assign w_timeout   = (r_idle_cnt == IW'(TIMEOUT));
  assign w_tx_acc    = tx_valid && tx_ready;
  assign w_last_pop  = (r_state == ST_ARB_PAYLOAD) && w_tx_acc && (w_count == 8'd1);

  assign req_ready = ((r_state == ST_ARB_COLLECT) && w_room) ? w_grant_oh : '0;
  assign tx_valid  = (r_state == ST_ARB_HEADER) || (r_state == ST_ARB_LEN) ||
                     (r_state == ST_ARB_PAYLOAD);
  assign grant_id  = (r_state == ST_ARB_IDLE) ? 4'd0 : r_grant;
  assign busy      = (r_state != ST_ARB_IDLE);
  assign dbg_state = r_state;

  always_comb begin
    tx_data = 8'h00;
    case (r_state)
      ST_ARB_HEADER:  tx_data = build_hdr(HDR_TAG, r_grant);
      ST_ARB_LEN:     tx_data = w_count;
      ST_ARB_PAYLOAD: tx_data = w_rd_data;
      default:        tx_data = 8'h00;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ARB_IDLE:    if (w_found) w_next = ST_ARB_COLLECT;
      ST_ARB_COLLECT: begin
        if (w_close) w_next = ST_ARB_HEADER;
        else if (!w_beat && w_timeout)
          w_next = (w_count != 8'd0) ? ST_ARB_HEADER : ST_ARB_IDLE;
      end
      ST_ARB_HEADER:  if (w_tx_acc) w_next = ST_ARB_LEN;
      ST_ARB_LEN:     if (w_tx_acc) w_next = ST_ARB_PAYLOAD;
      ST_ARB_PAYLOAD: if (w_last_pop) w_next = ST_ARB_IDLE;
      default:        w_next = ST_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_state    <= ST_ARB_IDLE;
      r_grant    <= '0;
      r_rr       <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_ARB_IDLE) && w_found) begin
        r_grant    <= w_pick;
        r_idle_cnt <= '0;
      end
      if (r_state == ST_ARB_COLLECT) begin
        if (w_beat) r_idle_cnt <= '0;
        else if (!w_timeout) r_idle_cnt <= r_idle_cnt + IW'(1);
      end
      // An empty grant that times out also hands priority to the next channel.
      if (((r_state == ST_ARB_COLLECT) && !w_beat && w_timeout && (w_count == 8'd0)) ||
          w_last_pop)
        r_rr <= w_rr_inc;
    end
  end

  ftdi_frame_buf #(
    .DEPTH(MAX_BURST)
  ) u_buf (
    .clock_in(clock_in),
    .flush   (!reset_n),
    .wr_en   (w_beat),
    .wr_data (w_sel_data),
    .rd_en   ((r_state == ST_ARB_PAYLOAD) && w_tx_acc),
    .rd_data (w_rd_data),
    .count   (w_count)
  );

endmodule
